crypto_top: RTL and testbench
=============================

Name: crypto_top

Overview:
Single-clock crypto datapath. Performs Simplified-DES (S-DES) encryption or decryption of an 8-bit block under a 10-bit key. Each cycle it registers the result on sdes_data_out. It also folds every registered S-DES output into a running 32-bit FNV-1a-style hash on final_hash. It is the top of the crypto demo subsystem; inputs may change on any cycle.

Parameters:
HASH_INIT, 32'h811C9DC5, value loaded into the hash register on reset.
HASH_PRIME, 32'h01000193, multiplier used in each hash absorption step.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
data_in  input  8  plaintext (mode=0) or ciphertext (mode=1)
key  input  10  S-DES key
mode  input  1  0 = encrypt, 1 = decrypt
sdes_data_out  output  8  registered S-DES result
final_hash  output  32  registered running hash

Behaviour:
- Reset (synchronous, priority over everything): sdes_data_out <= 8'h00; final_hash <= HASH_INIT.
- Bit numbering for all permutations: position 1 = MSB.
- Key schedule (combinational from key):
  - P10 = 3 5 2 7 4 10 1 9 8 6.
  - Split into two 5-bit halves.
  - K1 = P8(both halves rotated left 1).
  - K2 = P8(both halves rotated left 3 total).
  - P8 = 6 3 7 4 8 5 10 9.
- Cipher (combinational): IP, then fK(first key), then SW (swap 4-bit halves), then fK(second key), then IP^-1.
  - IP = 2 6 3 1 4 8 5 7; IP^-1 = 4 1 3 5 7 2 8 6.
  - Encrypt: first key = K1, second key = K2. Decrypt: first key = K2, second key = K1.
- fK(L,R,K) = (L xor F(R,K), R).
  - F: EP = 4 1 2 3 2 3 4 1 applied to R, xor K.
  - Left nibble goes to S0, right nibble to S1. Row = bits 1,4; column = bits 2,3.
  - Concatenate S0 (2 bits) and S1 (2 bits), then apply P4 = 2 4 3 1.
- S0 rows: [1 0 3 2] [3 2 1 0] [0 2 1 3] [3 1 3 2].
- S1 rows: [0 1 2 3] [2 0 1 3] [3 0 1 0] [2 1 0 3].
- Latency: sdes_data_out reflects data_in/key/mode sampled at the previous rising edge (1 cycle). Inputs changed between edges take effect at the next edge; no handshake, no valid signal.
- Decrypt(Encrypt(p,k),k) = p for all 256×1024 combinations.
- Hash: every non-reset edge, final_hash <= ((final_hash xor {24'h0, sdes_data_out}) * HASH_PRIME) mod 2^32.
  - Uses the pre-edge (old) sdes_data_out, so hash trails the cipher output by one cycle.
  - A repeated identical output is still absorbed each cycle.
  - Only reset clears the hash.
- Reset asserted mid-stream: both registers return to their reset values at that edge. Absorption resumes on the first edge with reset low, starting with byte 8'h00.
- No X propagation: all outputs are defined from the first reset edge onward.

Test Plan:
- Reset held 2 cycles -> sdes_data_out=8'h00, final_hash=32'h811C9DC5. First edge after release: final_hash=32'h050C5D1F (0x811C9DC5 × 0x01000193 mod 2^32).
- Encrypt, key=10'h282, data_in=8'h97, mode=0; after 1 edge -> sdes_data_out=8'h38.
- Decrypt, key=10'h282, data_in=8'h38, mode=1; after 1 edge -> sdes_data_out=8'h97.
- Round trip: key=10'h1A5, data_in=8'hA9 encrypt; feed the output back with mode=1 -> sdes_data_out=8'hA9.
  - Repeat for (00,000), (FF,3FF), (AA,155), (5A,2A5), (C3,3C3); each returns the original plaintext.
- Hash model check: random stream over 200 cycles. Compare final_hash each cycle against a reference model absorbing the previous-cycle sdes_data_out; must match exactly.
- Reset asserted mid-stream for 1 cycle -> next edge outputs 8'h00/HASH_INIT; subsequent hash sequence equals a fresh run with the same inputs.

Source files
------------

// File: rtl/crypto_top.sv
// crypto_top: one-cycle registered S-DES encrypt/decrypt of an 8-bit block
// under a 10-bit key, plus a running 32-bit FNV-1a-style hash that absorbs
// every registered cipher output.
module crypto_top #(
   parameter logic [31:0] HASH_INIT  = 32'h811C9DC5,
   parameter logic [31:0] HASH_PRIME = 32'h01000193
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic [9:0]  key,
   input  logic        mode,
   output logic [7:0]  sdes_data_out,
   output logic [31:0] final_hash
);

   // Permutations: table position 1 is the MSB, so position p of an n-bit
   // vector is bit [n-p].

   // P10 = 3 5 2 7 4 10 1 9 8 6
   function automatic logic [9:0] p10(input logic [9:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   // P8 = 6 3 7 4 8 5 10 9
   function automatic logic [7:0] p8(input logic [9:0] k);
      return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
   endfunction

   // IP = 2 6 3 1 4 8 5 7
   function automatic logic [7:0] ip(input logic [7:0] d);
      return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
   endfunction

   // IP^-1 = 4 1 3 5 7 2 8 6
   function automatic logic [7:0] ip_inv(input logic [7:0] d);
      return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
   endfunction

   // EP = 4 1 2 3 2 3 4 1
   function automatic logic [7:0] ep(input logic [3:0] r);
      return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
   endfunction

   // P4 = 2 4 3 1
   function automatic logic [3:0] p4(input logic [3:0] s);
      return {s[2], s[0], s[1], s[3]};
   endfunction

   // 5-bit rotate left by 1
   function automatic logic [4:0] rol1(input logic [4:0] h);
      return {h[3:0], h[4]};
   endfunction

   // 5-bit rotate left by 3
   function automatic logic [4:0] rol3(input logic [4:0] h);
      return {h[1:0], h[4:2]};
   endfunction

   // S0: row = bits 1,4 ; column = bits 2,3
   function automatic logic [1:0] sbox0(input logic [3:0] n);
      logic [3:0] idx;
      logic [1:0] v;
      idx = {n[3], n[0], n[2], n[1]};
      case (idx)
         4'd0:  v = 2'd1;
         4'd1:  v = 2'd0;
         4'd2:  v = 2'd3;
         4'd3:  v = 2'd2;
         4'd4:  v = 2'd3;
         4'd5:  v = 2'd2;
         4'd6:  v = 2'd1;
         4'd7:  v = 2'd0;
         4'd8:  v = 2'd0;
         4'd9:  v = 2'd2;
         4'd10: v = 2'd1;
         4'd11: v = 2'd3;
         4'd12: v = 2'd3;
         4'd13: v = 2'd1;
         4'd14: v = 2'd3;
         default: v = 2'd2;
      endcase
      return v;
   endfunction

   // S1: row = bits 1,4 ; column = bits 2,3
   function automatic logic [1:0] sbox1(input logic [3:0] n);
      logic [3:0] idx;
      logic [1:0] v;
      idx = {n[3], n[0], n[2], n[1]};
      case (idx)
         4'd0:  v = 2'd0;
         4'd1:  v = 2'd1;
         4'd2:  v = 2'd2;
         4'd3:  v = 2'd3;
         4'd4:  v = 2'd2;
         4'd5:  v = 2'd0;
         4'd6:  v = 2'd1;
         4'd7:  v = 2'd3;
         4'd8:  v = 2'd3;
         4'd9:  v = 2'd0;
         4'd10: v = 2'd1;
         4'd11: v = 2'd0;
         4'd12: v = 2'd2;
         4'd13: v = 2'd1;
         4'd14: v = 2'd0;
         default: v = 2'd3;
      endcase
      return v;
   endfunction

   // Round function F(R, K)
   function automatic logic [3:0] f_func(input logic [3:0] r, input logic [7:0] k);
      logic [7:0] x;
      x = ep(r) ^ k;
      return p4({sbox0(x[7:4]), sbox1(x[3:0])});
   endfunction

   // fK(L, R, K) = (L xor F(R, K), R)
   function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] k);
      return {d[7:4] ^ f_func(d[3:0], k), d[3:0]};
   endfunction

   logic [9:0]  key_p10;
   logic [7:0]  k1;
   logic [7:0]  k2;
   logic [7:0]  key_a;
   logic [7:0]  key_b;
   logic [7:0]  stage_ip;
   logic [7:0]  stage_r1;
   logic [7:0]  stage_sw;
   logic [7:0]  stage_r2;
   logic [7:0]  sdes_next;
   logic [31:0] hash_next;

   // Key schedule and cipher datapath; decrypt simply swaps the subkey order
   always_comb begin
      key_p10   = p10(key);
      k1        = p8({rol1(key_p10[9:5]), rol1(key_p10[4:0])});
      k2        = p8({rol3(key_p10[9:5]), rol3(key_p10[4:0])});
      key_a     = mode ? k2 : k1;
      key_b     = mode ? k1 : k2;
      stage_ip  = ip(data_in);
      stage_r1  = fk(stage_ip, key_a);
      stage_sw  = {stage_r1[3:0], stage_r1[7:4]};
      stage_r2  = fk(stage_sw, key_b);
      sdes_next = ip_inv(stage_r2);
      hash_next = (final_hash ^ {24'h0, sdes_data_out}) * HASH_PRIME;
   end

   // Output and hash registers; hash absorbs the pre-edge cipher output
   always_ff @(posedge clk) begin
      if (reset) begin
         sdes_data_out <= '0;
         final_hash    <= HASH_INIT;
      end else begin
         sdes_data_out <= sdes_next;
         final_hash    <= hash_next;
      end
   end

endmodule

// File: tb/tb_crypto_top.sv
// tb_crypto_top: randomized scoreboard bench for crypto_top with a
// table-driven S-DES reference model and an arithmetic hash model.
module tb_crypto_top;

   localparam logic [31:0] HASH_INIT  = 32'h811C9DC5;
   localparam logic [31:0] HASH_PRIME = 32'h01000193;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  data_in = '0;
   logic [9:0]  key = '0;
   logic        mode = 1'b0;
   logic [7:0]  sdes_data_out;
   logic [31:0] final_hash;

   crypto_top #(.HASH_INIT(HASH_INIT), .HASH_PRIME(HASH_PRIME)) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .key(key),
      .mode(mode),
      .sdes_data_out(sdes_data_out),
      .final_hash(final_hash)
   );

   always #5 clk = ~clk;

   // Reference permutation tables (1-based, position 1 = MSB)
   int T_P10[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   int T_P8[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
   int T_IP[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
   int T_IPI[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
   int T_EP[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
   int T_P4[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
   int S0[16]    = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
   int S1[16]    = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

   function automatic int perm(input int v, input int nin, input int nout, input int t[10]);
      int r;
      r = 0;
      for (int i = 0; i < nout; i++)
         r = (r << 1) | ((v >> (nin - t[i])) & 1);
      return r;
   endfunction

   function automatic int rot5(input int h, input int n);
      return ((h << n) | (h >> (5 - n))) & 31;
   endfunction

   function automatic int sb(input int n, input int tbl[16]);
      int row;
      int col;
      row = ((n >> 3) & 1) * 2 + (n & 1);
      col = (n >> 1) & 3;
      return tbl[row * 4 + col];
   endfunction

   function automatic int ref_round(input int x, input int k);
      int e;
      int f;
      e = perm(x & 15, 4, 8, T_EP) ^ k;
      f = perm(sb(e >> 4, S0) * 4 + sb(e & 15, S1), 4, 4, T_P4);
      return (((x >> 4) ^ f) << 4) | (x & 15);
   endfunction

   function automatic logic [7:0] ref_sdes(input int p, input int k, input int dec);
      int pk;
      int k1;
      int k2;
      int x;
      pk = perm(k, 10, 10, T_P10);
      k1 = perm((rot5(pk >> 5, 1) << 5) | rot5(pk & 31, 1), 10, 8, T_P8);
      k2 = perm((rot5(pk >> 5, 3) << 5) | rot5(pk & 31, 3), 10, 8, T_P8);
      x  = perm(p, 8, 8, T_IP);
      x  = ref_round(x, dec ? k2 : k1);
      x  = ((x & 15) << 4) | (x >> 4);
      x  = ref_round(x, dec ? k1 : k2);
      return 8'(perm(x, 8, 8, T_IPI));
   endfunction

   typedef struct {
      logic [7:0]  sdes;
      logic [31:0] hash;
      bit          ks;
      logic [7:0]  ksdes;
      bit          kh;
      logic [31:0] khash;
   } exp_t;

   exp_t        scb[$];
   logic [7:0]  m_sdes;
   logic [31:0] m_hash;
   int          n_checks = 0;
   int          n_fail = 0;

   // Drive one cycle of inputs and push the model's post-edge expectation
   task automatic drive(input bit r, input logic [7:0] d, input logic [9:0] k,
                        input bit m, input bit ks, input logic [7:0] kv,
                        input bit kh, input logic [31:0] khv);
      exp_t e;
      @(negedge clk);
      reset   = r;
      data_in = d;
      key     = k;
      mode    = m;
      if (r) begin
         m_sdes = 8'h00;
         m_hash = HASH_INIT;
      end else begin
         m_hash = (m_hash ^ {24'h0, m_sdes}) * HASH_PRIME;
         m_sdes = ref_sdes(int'(d), int'(k), int'(m));
      end
      e.sdes = m_sdes; e.hash = m_hash;
      e.ks = ks; e.ksdes = kv; e.kh = kh; e.khash = khv;
      scb.push_back(e);
   endtask

   task automatic rnd(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 8'($urandom), 10'($urandom), 1'($urandom), 1'b0, '0, 1'b0, '0);
   endtask

   // Monitor: after each edge, pop one expectation and compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (scb.size() > 0) begin
            e = scb.pop_front();
            n_checks++;
            if (sdes_data_out !== e.sdes) begin
               n_fail++;
               $display("FAIL sdes_model: got %h expected %h", sdes_data_out, e.sdes);
            end
            n_checks++;
            if (final_hash !== e.hash) begin
               n_fail++;
               $display("FAIL hash_model: got %h expected %h", final_hash, e.hash);
            end
            if (e.ks) begin
               n_checks++;
               if (sdes_data_out !== e.ksdes) begin
                  n_fail++;
                  $display("FAIL sdes_known: got %h expected %h", sdes_data_out, e.ksdes);
               end
            end
            if (e.kh) begin
               n_checks++;
               if (final_hash !== e.khash) begin
                  n_fail++;
                  $display("FAIL hash_known: got %h expected %h", final_hash, e.khash);
               end
            end
         end
      end
   end

   logic [7:0] rt_p[6] = '{8'hA9, 8'h00, 8'hFF, 8'hAA, 8'h5A, 8'hC3};
   logic [9:0] rt_k[6] = '{10'h1A5, 10'h000, 10'h3FF, 10'h155, 10'h2A5, 10'h3C3};
   logic [7:0] rp_d[20];
   logic [9:0] rp_k[20];
   logic       rp_m[20];

   initial begin
      logic [7:0] c;
      int         guard;
      m_sdes = 8'h00;
      m_hash = HASH_INIT;

      // Reset held two cycles, then first absorption of byte 00
      drive(1'b1, 8'h00, 10'h000, 1'b0, 1'b1, 8'h00, 1'b1, HASH_INIT);
      drive(1'b1, 8'h00, 10'h000, 1'b0, 1'b1, 8'h00, 1'b1, HASH_INIT);
      drive(1'b0, 8'h97, 10'h282, 1'b0, 1'b1, 8'h38, 1'b1, 32'h050C5D1F);

      // Known decrypt vector
      drive(1'b0, 8'h38, 10'h282, 1'b1, 1'b1, 8'h97, 1'b0, '0);

      // Round trips: encrypt, then decrypt the model ciphertext
      for (int i = 0; i < 6; i++) begin
         c = ref_sdes(int'(rt_p[i]), int'(rt_k[i]), 0);
         drive(1'b0, rt_p[i], rt_k[i], 1'b0, 1'b0, '0, 1'b0, '0);
         drive(1'b0, c, rt_k[i], 1'b1, 1'b1, rt_p[i], 1'b0, '0);
      end

      // Random stream, including held identical inputs
      rnd(200);
      for (int i = 0; i < 5; i++)
         drive(1'b0, 8'h3C, 10'h111, 1'b0, 1'b0, '0, 1'b0, '0);

      // Mid-stream reset, then a fixed sequence replayed after a second reset
      for (int i = 0; i < 20; i++) begin
         rp_d[i] = 8'($urandom);
         rp_k[i] = 10'($urandom);
         rp_m[i] = 1'($urandom);
      end
      for (int pass = 0; pass < 2; pass++) begin
         drive(1'b1, 8'($urandom), 10'($urandom), 1'b0, 1'b1, 8'h00, 1'b1, HASH_INIT);
         drive(1'b0, rp_d[0], rp_k[0], rp_m[0], 1'b0, '0, 1'b1, 32'h050C5D1F);
         for (int i = 1; i < 20; i++)
            drive(1'b0, rp_d[i], rp_k[i], rp_m[i], 1'b0, '0, 1'b0, '0);
         rnd(15);
      end

      // Drain the scoreboard with a bounded wait
      guard = 0;
      while (scb.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (scb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", scb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
